inv_sub_bytes_seq: RTL

INV_SUB_BYTES_SEQ -- requirements
Module: inv_sub_bytes_seq

---
 rtl/inv_sub_bytes_seq_pkg.sv | 14 +
 rtl/inv_sub_bytes_seq_inv_sbox.sv | 32 +++
 rtl/inv_sub_bytes_seq.sv | 96 +++++++++
 3 files changed

// File: rtl/inv_sub_bytes_seq_pkg.sv
// Shared types and constants for the sequential AES InvSubBytes block.
package inv_sub_bytes_seq_pkg;

  localparam int BLOCK_BYTES = 16;

  typedef logic [8*BLOCK_BYTES-1:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/inv_sub_bytes_seq_inv_sbox.sv
// FIPS-197 inverse S-box: purely combinational 256-entry lookup.
module inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Row r holds InvSbox(0xr0) .. InvSbox(0xrf), entry 0x00 in the top byte.
  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] w_msb;

  assign w_msb  = 11'd2047 - {i_byte, 3'b000};
  assign o_byte = INV_SBOX_TABLE[w_msb -: 8];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: substitutes BYTES_PER_CYCLE state bytes per BUSY
// cycle in place, then holds the result until the consumer takes it.
module inv_sub_bytes_seq
  import inv_sub_bytes_seq_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NUM_GROUPS = BLOCK_BYTES / BYTES_PER_CYCLE;
  localparam int GRP_W      = 8 * BYTES_PER_CYCLE;
  localparam int CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NUM_GROUPS - 1);

  fsm_state_e       r_fsm;
  logic [CNT_W-1:0] r_cnt;
  aes_state_t       r_state;

  logic [GRP_W-1:0] w_group;
  logic [GRP_W-1:0] w_sub_group;
  aes_state_t       w_state_nxt;
  logic             w_last;

  // Byte-group multiplexer and in-place write-back; group 0 is the top bytes.
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_group     = '0;
    w_state_nxt = r_state;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (r_cnt == CNT_W'(g)) begin
        w_group = r_state[127 - g*GRP_W -: GRP_W];
        w_state_nxt[127 - g*GRP_W -: GRP_W] = w_sub_group;
      end
    end
  end

  for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .i_byte(w_group[GRP_W-1-8*b -: 8]),
      .o_byte(w_sub_group[GRP_W-1-8*b -: 8])
    );
  end

  assign w_last = (r_cnt == LAST_GROUP);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the state register is a plain register, not a RAM, so it is
      // cleared on reset to keep out_data deterministic after an abort.
      r_fsm   <= ST_IDLE;
      r_cnt   <= '0;
      r_state <= '0;
    end else begin
      unique case (r_fsm)
        ST_IDLE: begin
          if (in_valid) begin
            r_state <= in_data;
            r_cnt   <= '0;
            r_fsm   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_state <= w_state_nxt;
          if (w_last) begin
            r_cnt <= '0;
            r_fsm <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) r_fsm <= ST_IDLE;
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_fsm == ST_IDLE);
  assign out_valid = (r_fsm == ST_DONE);
  assign busy      = (r_fsm != ST_IDLE);
  assign out_data  = r_state;

endmodule
